multicycle_ctrl_fsm: RTL and testbench

//  Parametrised multicycle MIPS control FSM; successor of the fixed-latency add/sub/addi controller.

---
 rtl/multicycle_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute sequencing
// with configurable memory waits and an illegal-instruction trap.
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT     = 3,
  parameter int LOAD_WAIT    = 3,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  OPCODE,
  input  logic [15:0] OFFSET,
  input  logic        Zero,
  output logic        PC_control,
  output logic        PC_cond,
  output logic [1:0]  PCSource,
  output logic        IorD,
  output logic        ReadWrite,
  output logic        IRWrite,
  output logic        MDRWrite,
  output logic        AWrite,
  output logic        BWrite,
  output logic        ULAout_ctrl,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [2:0]  ULAop,
  output logic        srcA_selector,
  output logic [1:0]  srcB_selector,
  output logic [2:0]  REGDEST_SELETOR,
  output logic        reset_out,
  output logic        illegal_op
);

  localparam int MAXW = (MEM_WAIT > LOAD_WAIT) ? MEM_WAIT : LOAD_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] MW_LAST = CW'(MEM_WAIT);
  localparam logic [CW-1:0] LW_LAST = CW'(LOAD_WAIT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_RST  = 6'b111111;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R,
    S_EXEC_I, S_WB_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef struct packed {
    logic       pcc;
    logic       pcd;
    logic [1:0] pcs;
    logic       iord;
    logic       rw;
    logic       irw;
    logic       mdrw;
    logic       aw;
    logic       bw;
    logic       uo;
    logic       regw;
    logic       m2r;
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] rd;
    logic       rso;
    logic       ill;
  } ctl_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, ncnt;
  logic [2:0]    r_alu, n_alu;
  logic          r_ld, n_ld;
  ctl_t          ctl;

  logic [5:0] funct;
  logic f_add, f_sub, f_and;
  logic d_r, d_addi, d_lw, d_sw, d_beq, d_j, d_rst;
  logic unused_ok;

  assign funct     = OFFSET[5:0];
  assign unused_ok = ^{Zero, OFFSET[15:6]};

  assign f_add  = funct == 6'b100000;
  assign f_sub  = funct == 6'b100010;
  assign f_and  = funct == 6'b100100;
  assign d_r    = (OPCODE == OP_R) && (f_add || f_sub || f_and);
  assign d_addi = OPCODE == OP_ADDI;
  assign d_lw   = OPCODE == OP_LW;
  assign d_sw   = OPCODE == OP_SW;
  assign d_beq  = OPCODE == OP_BEQ;
  assign d_j    = OPCODE == OP_J;
  assign d_rst  = OPCODE == OP_RST;

  always_comb begin
    nxt   = state;
    ncnt  = '0;
    n_alu = r_alu;
    n_ld  = r_ld;
    unique case (state)
      S_RESET:    nxt = S_FETCH;
      S_FETCH: begin
        if (cnt == MW_LAST) nxt = S_DECODE;
        else ncnt = cnt + 1'b1;
      end
      S_DECODE: begin
        n_ld = d_lw;
        unique case (1'b1)
          f_sub:   n_alu = 3'b010;
          f_and:   n_alu = 3'b011;
          default: n_alu = 3'b001;
        endcase
        unique case (1'b1)
          d_r:          nxt = S_EXEC_R;
          d_addi:       nxt = S_EXEC_I;
          d_lw || d_sw: nxt = S_MEM_ADDR;
          d_beq:        nxt = S_BRANCH;
          d_j:          nxt = S_JUMP;
          d_rst:        nxt = S_RESET;
          default:      nxt = S_TRAP;
        endcase
      end
      S_EXEC_R:   nxt = S_WB_R;
      S_EXEC_I:   nxt = S_WB_I;
      S_MEM_ADDR: nxt = r_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (cnt == LW_LAST) nxt = S_MEM_WB;
        else ncnt = cnt + 1'b1;
      end
      S_TRAP:     nxt = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
      default:    nxt = S_FETCH;
    endcase
  end

  // Outputs for the state being entered, so they are registered yet Moore-timed
  function automatic ctl_t dec(input state_t s,
                               input logic [CW-1:0] c,
                               input logic [2:0] alu);
    ctl_t o;
    o = '0;
    unique case (s)
      S_RESET: o.rso = 1'b1;
      S_FETCH: begin
        o.sb  = 2'b01;
        o.alu = 3'b001;
        o.pcc = (c == MW_LAST);
        o.irw = (c == MW_LAST);
      end
      S_DECODE: begin
        o.aw  = 1'b1;
        o.bw  = 1'b1;
        o.sb  = 2'b11;
        o.alu = 3'b001;
        o.uo  = 1'b1;
      end
      S_EXEC_R: begin
        o.sa  = 1'b1;
        o.alu = alu;
        o.uo  = 1'b1;
      end
      S_WB_R: begin
        o.regw = 1'b1;
        o.rd   = 3'b001;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        o.sa  = 1'b1;
        o.sb  = 2'b10;
        o.alu = 3'b001;
        o.uo  = 1'b1;
      end
      S_WB_I:   o.regw = 1'b1;
      S_MEM_RD: begin
        o.iord = 1'b1;
        o.mdrw = (c == LW_LAST);
      end
      S_MEM_WB: begin
        o.regw = 1'b1;
        o.m2r  = 1'b1;
      end
      S_MEM_WR: begin
        o.iord = 1'b1;
        o.rw   = 1'b1;
      end
      S_BRANCH: begin
        o.sa  = 1'b1;
        o.alu = 3'b010;
        o.pcd = 1'b1;
        o.pcs = 2'b01;
      end
      S_JUMP: begin
        o.pcc = 1'b1;
        o.pcs = 2'b10;
      end
      S_TRAP:  o.ill = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_RESET;
      cnt     <= '0;
      r_alu   <= 3'b001;
      r_ld    <= 1'b0;
      ctl     <= '0;
      ctl.rso <= 1'b1;
    end else begin
      state <= nxt;
      cnt   <= ncnt;
      r_alu <= n_alu;
      r_ld  <= n_ld;
      ctl   <= dec(nxt, ncnt, n_alu);
    end
  end

  assign PC_control      = ctl.pcc;
  assign PC_cond         = ctl.pcd;
  assign PCSource        = ctl.pcs;
  assign IorD            = ctl.iord;
  assign ReadWrite       = ctl.rw;
  assign IRWrite         = ctl.irw;
  assign MDRWrite        = ctl.mdrw;
  assign AWrite          = ctl.aw;
  assign BWrite          = ctl.bw;
  assign ULAout_ctrl     = ctl.uo;
  assign RegWrite        = ctl.regw;
  assign MemToReg        = ctl.m2r;
  assign ULAop           = ctl.alu;
  assign srcA_selector   = ctl.sa;
  assign srcB_selector   = ctl.sb;
  assign REGDEST_SELETOR = ctl.rd;
  assign reset_out       = ctl.rso;
  assign illegal_op      = ctl.ill;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Random instruction stream against a per-instruction control
// sequence model, on a default build and a short-wait no-trap build.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       pcc;
    logic       pcd;
    logic [1:0] pcs;
    logic       iord;
    logic       rw;
    logic       irw;
    logic       mdrw;
    logic       aw;
    logic       bw;
    logic       uo;
    logic       regw;
    logic       m2r;
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] rd;
    logic       rso;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic [5:0]  op_a = '0, op_b = '0;
  logic [15:0] off_a = '0, off_b = '0;
  logic        z_a = 1'b0, z_b = 1'b0;
  wire ctl_t   oa, ob;

  int mw [2]  = '{3, 1};
  int lwt [2] = '{3, 2};
  int trp [2] = '{1, 0};

  int n_run = 0;
  int n_bad = 0;
  ctl_t expq [$];

  multicycle_ctrl_fsm dut_a (
    .clock(clk), .reset(rst_a),
    .OPCODE(op_a), .OFFSET(off_a), .Zero(z_a),
    .PC_control(oa.pcc), .PC_cond(oa.pcd),
    .PCSource(oa.pcs), .IorD(oa.iord),
    .ReadWrite(oa.rw), .IRWrite(oa.irw),
    .MDRWrite(oa.mdrw), .AWrite(oa.aw),
    .BWrite(oa.bw), .ULAout_ctrl(oa.uo),
    .RegWrite(oa.regw), .MemToReg(oa.m2r),
    .ULAop(oa.alu), .srcA_selector(oa.sa),
    .srcB_selector(oa.sb), .REGDEST_SELETOR(oa.rd),
    .reset_out(oa.rso), .illegal_op(oa.ill)
  );

  multicycle_ctrl_fsm #(
    .MEM_WAIT(1), .LOAD_WAIT(2), .ILLEGAL_TRAP(1'b0)
  ) dut_b (
    .clock(clk), .reset(rst_b),
    .OPCODE(op_b), .OFFSET(off_b), .Zero(z_b),
    .PC_control(ob.pcc), .PC_cond(ob.pcd),
    .PCSource(ob.pcs), .IorD(ob.iord),
    .ReadWrite(ob.rw), .IRWrite(ob.irw),
    .MDRWrite(ob.mdrw), .AWrite(ob.aw),
    .BWrite(ob.bw), .ULAout_ctrl(ob.uo),
    .RegWrite(ob.regw), .MemToReg(ob.m2r),
    .ULAop(ob.alu), .srcA_selector(ob.sa),
    .srcB_selector(ob.sb), .REGDEST_SELETOR(ob.rd),
    .reset_out(ob.rso), .illegal_op(ob.ill)
  );

  task automatic chk(input string tag, input ctl_t got,
                     input ctl_t exp);
    n_run++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t obs(input int d);
    return d == 0 ? oa : ob;
  endfunction

  function automatic ctl_t rstv();
    ctl_t c;
    c = '0;
    c.rso = 1'b1;
    return c;
  endfunction

  // Expected per-cycle control words for one instruction, fetch to last step
  function automatic void model(input int d, input logic [5:0] op,
                                input logic [5:0] fn);
    ctl_t c, ex;
    expq.delete();
    for (int i = 0; i <= mw[d]; i++) begin
      c = '0;
      c.sb = 2'b01;
      c.alu = 3'b001;
      if (i == mw[d]) begin
        c.pcc = 1'b1;
        c.irw = 1'b1;
      end
      expq.push_back(c);
    end
    c = '0;
    c.aw = 1'b1; c.bw = 1'b1; c.sb = 2'b11;
    c.alu = 3'b001; c.uo = 1'b1;
    expq.push_back(c);
    ex = '0;
    ex.sa = 1'b1; ex.sb = 2'b10;
    ex.alu = 3'b001; ex.uo = 1'b1;
    case (op)
      6'h00: begin
        c = '0;
        c.sa = 1'b1; c.uo = 1'b1;
        c.alu = fn == 6'h20 ? 3'd1 : fn == 6'h22 ? 3'd2 : 3'd3;
        expq.push_back(c);
        c = '0;
        c.regw = 1'b1; c.rd = 3'b001;
        expq.push_back(c);
      end
      6'h08: begin
        expq.push_back(ex);
        c = '0;
        c.regw = 1'b1;
        expq.push_back(c);
      end
      6'h23: begin
        expq.push_back(ex);
        for (int k = 0; k < lwt[d]; k++) begin
          c = '0;
          c.iord = 1'b1;
          c.mdrw = (k == lwt[d] - 1);
          expq.push_back(c);
        end
        c = '0;
        c.regw = 1'b1; c.m2r = 1'b1;
        expq.push_back(c);
      end
      6'h2B: begin
        expq.push_back(ex);
        c = '0;
        c.iord = 1'b1; c.rw = 1'b1;
        expq.push_back(c);
      end
      6'h04: begin
        c = '0;
        c.sa = 1'b1; c.alu = 3'b010;
        c.pcd = 1'b1; c.pcs = 2'b01;
        expq.push_back(c);
      end
      6'h02: begin
        c = '0;
        c.pcc = 1'b1; c.pcs = 2'b10;
        expq.push_back(c);
      end
      6'h3F: expq.push_back(rstv());
      default: begin
        c = '0;
        c.ill = 1'b1;
        for (int k = 0; k < (trp[d] != 0 ? 20 : 1); k++)
          expq.push_back(c);
      end
    endcase
  endfunction

  task automatic drive(input int d, input logic [5:0] op,
                       input logic [5:0] fn);
    logic [15:0] off;
    off = {10'($urandom), fn};
    if (d == 0) begin
      op_a = op; off_a = off; z_a = 1'($urandom);
    end else begin
      op_b = op; off_b = off; z_b = 1'($urandom);
    end
  endtask

  task automatic set_rst(input int d, input logic v);
    if (d == 0) rst_a = v;
    else rst_b = v;
  endtask

  task automatic do_reset(input int d);
    set_rst(d, 1'b1);
    step();
    step();
    chk($sformatf("rst_hold_d%0d", d), obs(d), rstv());
    set_rst(d, 1'b0);
    chk($sformatf("rst_cycle_d%0d", d), obs(d), rstv());
    step();
  endtask

  task automatic run(input int d, input logic [5:0] op,
                     input logic [5:0] fn, input string nm);
    drive(d, op, fn);
    model(d, op, fn);
    foreach (expq[i]) begin
      chk($sformatf("%s_d%0d_c%0d", nm, d, i + 1), obs(d), expq[i]);
      step();
    end
    if (op != 6'h3F && op != 6'h00 && op != 6'h08 &&
        op != 6'h23 && op != 6'h2B && op != 6'h04 &&
        op != 6'h02 && trp[d] != 0)
      do_reset(d);
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h08 || op == 6'h23 ||
           op == 6'h2B || op == 6'h04 || op == 6'h02 ||
           op == 6'h3F;
  endfunction

  task automatic run_rand(input int d, input bit allow_ill);
    int k;
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] ops [8];
    logic [5:0] fns [3];
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h15};
    fns = '{6'h20, 6'h22, 6'h24};
    k = $urandom_range(0, allow_ill ? 7 : 6);
    op = ops[k];
    fn = fns[$urandom_range(0, 2)];
    if (k == 7) begin
      op = 6'($urandom);
      while (legal(op)) op = 6'($urandom);
    end
    run(d, op, fn, "rnd");
  endtask

  task automatic mid_reset(input int d);
    drive(d, 6'h23, 6'h00);
    model(d, 6'h23, 6'h00);
    for (int i = 0; i < mw[d] + 4; i++) begin
      chk($sformatf("lwpre_d%0d_c%0d", d, i + 1), obs(d), expq[i]);
      step();
    end
    #3;
    set_rst(d, 1'b1);
    #1;
    chk($sformatf("mid_rst_d%0d", d), obs(d), rstv());
    @(posedge clk);
    #1;
    set_rst(d, 1'b0);
    chk($sformatf("mid_rst_cycle_d%0d", d), obs(d), rstv());
    step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      run(d, 6'h00, 6'h20, "add");
      run(d, 6'h00, 6'h22, "sub");
      run(d, 6'h00, 6'h24, "and");
      run(d, 6'h08, 6'h00, "addi");
      run(d, 6'h23, 6'h00, "lw");
      run(d, 6'h2B, 6'h00, "sw");
      run(d, 6'h04, 6'h00, "beq");
      run(d, 6'h02, 6'h00, "j");
      run(d, 6'h3F, 6'h00, "rstop");
      for (int n = 0; n < 25; n++) run_rand(d, d == 1);
      mid_reset(d);
      run(d, 6'h23, 6'h00, "lw2");
      run(d, 6'h15, 6'h00, "ill");
      for (int n = 0; n < 10; n++) run_rand(d, 1'b1);
      run(d, 6'h02, 6'h00, "j2");
      set_rst(d, 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_bad);
    $finish;
  end

endmodule
